// File: rtl/bit_population_generator.sv
// rtl/bit_population_generator.sv - emits a word with a requested number of LFSR-placed set bits
module bit_population_generator #(
  parameter int          DATA_W    = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                      clk_i,
  input  logic                      arstn_i,
  input  logic [$clog2(DATA_W)+1:0] cnt_i,
  input  logic                      cnt_val_i,
  output logic                      cnt_ready_o,
  output logic [DATA_W-1:0]         data_o,
  output logic                      data_val_o,
  input  logic                      data_ready_i
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam int CNT_W = IDX_W + 2;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);
  localparam logic [IDX_W:0]   FULL_REM = (IDX_W+1)'(DATA_W);
  localparam logic [15:0]      TAPS     = 16'hB400;

  typedef enum logic [1:0] {IDLE, BUILD, OUT} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mask, mask_nxt;
  logic [IDX_W:0]      remaining, remaining_nxt;
  logic [15:0]         lfsr, lfsr_nxt, lfsr_adv;
  logic [IDX_W:0]      sat_cnt;
  logic [IDX_W-1:0]    pos, target, idx;

  // Compare at full request width so oversized counts saturate instead of wrapping.
  assign sat_cnt  = (cnt_i > FULL_CNT) ? FULL_REM : cnt_i[IDX_W:0];
  assign pos      = lfsr[IDX_W-1:0];
  assign lfsr_adv = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);

  // Descending loop so the nearest clear bit above pos (modulo DATA_W) wins.
  always_comb begin
    target = '0;
    idx    = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      idx = pos + IDX_W'(i);
      if (!mask[idx]) target = idx;
    end
  end

  always_comb begin
    state_nxt     = state;
    mask_nxt      = mask;
    remaining_nxt = remaining;
    lfsr_nxt      = lfsr;
    case (state)
      IDLE: begin
        if (cnt_val_i) begin
          mask_nxt      = '0;
          remaining_nxt = sat_cnt;
          state_nxt     = (sat_cnt != '0) ? BUILD : OUT;
        end
      end
      BUILD: begin
        mask_nxt      = mask | (DATA_W'(1) << target);
        remaining_nxt = remaining - 1'b1;
        lfsr_nxt      = lfsr_adv;
        if (remaining == (IDX_W+1)'(1)) state_nxt = OUT;
      end
      OUT: begin
        if (data_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state     <= IDLE;
      mask      <= '0;
      remaining <= '0;
      lfsr      <= LFSR_SEED;
    end else begin
      state     <= state_nxt;
      mask      <= mask_nxt;
      remaining <= remaining_nxt;
      lfsr      <= lfsr_nxt;
    end
  end

  assign cnt_ready_o = (state == IDLE);
  assign data_val_o  = (state == OUT);
  assign data_o      = mask;

endmodule

// File: tb/tb_bit_population_generator.sv
// tb/tb_bit_population_generator.sv - randomized checks against a behavioural generator model
module tb_bit_population_generator;

  localparam int          DW    = 16;
  localparam int          CW    = $clog2(DW) + 2;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic          clk_i = 1'b0;
  logic          arstn_i;
  logic [CW-1:0] cnt_i;
  logic          cnt_val_i;
  logic          cnt_ready_o;
  logic [DW-1:0] data_o;
  logic          data_val_o;
  logic          data_ready_i;

  int n_checks = 0;
  int n_fail   = 0;
  int model_lfsr;
  logic [DW-1:0] ref_word;
  logic [DW-1:0] fresh_word;

  bit_population_generator #(.DATA_W(DW), .LFSR_SEED(SEED)) dut (
    .clk_i        (clk_i),
    .arstn_i      (arstn_i),
    .cnt_i        (cnt_i),
    .cnt_val_i    (cnt_val_i),
    .cnt_ready_o  (cnt_ready_o),
    .data_o       (data_o),
    .data_val_o   (data_val_o),
    .data_ready_i (data_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: place each bit at lfsr mod DW, walking upward (wrapping) past taken slots.
  function automatic logic [DW-1:0] model_word(input int n);
    logic [DW-1:0] w;
    int p;
    w = '0;
    for (int k = 0; k < n; k++) begin
      p = model_lfsr % DW;
      while (w[p]) p = (p + 1) % DW;
      w[p] = 1'b1;
      if (model_lfsr % 2 == 1) model_lfsr = (model_lfsr / 2) ^ 'hB400;
      else                     model_lfsr = model_lfsr / 2;
    end
    return w;
  endfunction

  task automatic do_txn(input int n, input int stall);
    int exp_n;
    int lat;
    exp_n    = (n > DW) ? DW : n;
    ref_word = model_word(exp_n);
    chk("ready_idle", cnt_ready_o, 1);
    cnt_i        = CW'(n);
    cnt_val_i    = 1'b1;
    data_ready_i = (stall == 0);
    @(negedge clk_i);
    cnt_val_i = 1'b0;
    lat = 0;
    while (!data_val_o && lat < 300) begin
      @(negedge clk_i);
      lat++;
    end
    chk("latency", lat, exp_n);
    chk("data", data_o, ref_word);
    chk("popcount", $countones(data_o), exp_n);
    chk("ready_in_out", cnt_ready_o, 0);
    for (int s = 0; s < stall; s++) begin
      cnt_val_i = 1'($urandom_range(0, 1));
      cnt_i     = CW'($urandom_range(0, DW + 3));
      @(negedge clk_i);
      chk("stall_valid", data_val_o, 1);
      chk("stall_data", data_o, ref_word);
      chk("stall_ready", cnt_ready_o, 0);
    end
    cnt_val_i    = 1'b0;
    data_ready_i = 1'b1;
    @(negedge clk_i);
    chk("post_valid", data_val_o, 0);
    chk("post_ready", cnt_ready_o, 1);
    chk("post_hold", data_o, ref_word);
  endtask

  task automatic do_reset();
    arstn_i = 1'b0;
    repeat (2) @(negedge clk_i);
    arstn_i    = 1'b1;
    model_lfsr = SEED;
    @(negedge clk_i);
  endtask

  initial begin
    cnt_i        = '0;
    cnt_val_i    = 1'b0;
    data_ready_i = 1'b1;
    model_lfsr   = SEED;
    do_reset();
    chk("rst_ready", cnt_ready_o, 1);
    chk("rst_valid", data_val_o, 0);
    chk("rst_data", data_o, 0);

    do_txn(0, 0);
    do_txn(3, 0);
    do_txn(16, 0);
    chk("full16", ref_word, 16'hFFFF);
    do_txn(20, 0);
    chk("sat20", ref_word, 16'hFFFF);
    do_txn(5, 10);

    do_reset();
    do_txn(8, 0);
    fresh_word = ref_word;

    // Abort a transaction three cycles into BUILD.
    cnt_i     = CW'(8);
    cnt_val_i = 1'b1;
    @(negedge clk_i);
    cnt_val_i = 1'b0;
    repeat (3) @(negedge clk_i);
    arstn_i = 1'b0;
    #1;
    chk("abort_valid", data_val_o, 0);
    chk("abort_ready", cnt_ready_o, 1);
    @(negedge clk_i);
    arstn_i    = 1'b1;
    model_lfsr = SEED;
    @(negedge clk_i);
    chk("abort_no_out", data_val_o, 0);
    do_txn(8, 0);
    chk("abort_replay", data_o, fresh_word);

    for (int t = 0; t < 1000; t++) begin
      do_txn($urandom_range(0, DW + 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_population_generator.md
Name: bit_population_generator

Overview:
- Stimulus/source-side counterpart of the bit population counter.
- Accepts a requested population count and produces a DATA_W-bit word with exactly that many bits set.
- Set-bit positions are chosen by an internal LFSR, one bit per cycle.
- Output feeds data/valid consumers such as the population counter, for self-checking loopback and traffic generation.

Parameters:
- DATA_W, 16, output word width; power of two, 4..256.
- LFSR_SEED, 16'hACE1, initial 16-bit LFSR state; must be non-zero.

Ports:
- clk_i, input, 1, clock.
- arstn_i, input, 1, reset; asynchronous, active-low.
- cnt_i, input, $clog2(DATA_W)+2, requested number of set bits; same width as the population counter result.
- cnt_val_i, input, 1, request valid.
- cnt_ready_o, output, 1, request accepted when cnt_val_i && cnt_ready_o.
- data_o, output, DATA_W, generated word.
- data_val_o, output, 1, data_o valid.
- data_ready_i, input, 1, consumer accepts data_o when data_val_o && data_ready_i.

Behaviour:
- Reset (arstn_i low, asynchronous):
  - state=IDLE, mask=0, remaining=0, lfsr=LFSR_SEED.
  - data_o=0, data_val_o=0.
  - cnt_ready_o=1 (decoded from IDLE).
  - Reset mid-operation aborts the transaction; nothing is emitted.
- State machine IDLE / BUILD / OUT:
  - IDLE: cnt_ready_o=1.
    - On accept: mask<=0, remaining<=min(cnt_i, DATA_W); requests above DATA_W saturate to DATA_W.
    - Next state is BUILD if the saturated count is >0, else OUT.
    - cnt_val_i with no accept is ignored.
  - BUILD: cnt_ready_o=0. Each cycle:
    - IDX_W=$clog2(DATA_W); p=lfsr[IDX_W-1:0].
    - Target = first clear bit of mask scanning upward from p, wrapping DATA_W-1→0.
    - Set that bit in mask; remaining<=remaining-1; advance LFSR.
    - Exactly one new bit is set per cycle. When remaining reaches 0 after this cycle's set, go to OUT.
  - OUT: data_val_o=1, data_o=mask.
    - Both are held stable until data_ready_i=1; data_o must not change while stalled.
    - On handshake: data_val_o<=0, state<=IDLE.
- LFSR:
  - 16-bit Galois, taps 16'hB400.
  - Shift right; if the LSB was 1, XOR taps into the shifted value.
  - Advances only in BUILD cycles.
  - Not reseeded between transactions; only arstn_i reloads LFSR_SEED.
- Latency:
  - Request accepted at edge T → data_val_o high from edge T+1+N, where N=min(cnt_i, DATA_W).
  - N=0 → valid at T+1 with data_o=0.
  - Earliest next accept is one cycle after the output handshake (IDLE cycle). cnt_ready_o is never high in the same cycle as data_val_o.
- Output invariants:
  - popcount(data_o)==min(cnt_i, DATA_W) whenever data_val_o=1.
  - data_o holds the last emitted mask outside OUT until the next accept clears it.
- Arithmetic:
  - remaining is IDX_W+1 bits.
  - Saturation compare is done at cnt_i width before truncation; no wrap on cnt_i values ≥ DATA_W.
- Simultaneous events:
  - data_ready_i held high in OUT completes the handshake in one cycle.
  - cnt_val_i in BUILD/OUT is ignored (no queuing).

Test Plan:
- Reset release, cnt_i=0, cnt_val_i pulse, data_ready_i=1 → cnt_ready_o=1 after reset; data_val_o=1 one cycle after accept, data_o=16'h0000; back to IDLE next cycle.
- DATA_W=16, seed 16'hACE1, cnt_i=3 → data_val_o at T+4; popcount(data_o)=3; bit positions match a reference model of the LFSR plus wrap-around first-clear scan.
- cnt_i=16, then cnt_i=20 (saturation) → each output is 16'hFFFF at T+17. Wrap-around scan is exercised when the LFSR index hits an already-set bit.
- Hold data_ready_i=0 for 10 cycles in OUT while toggling cnt_val_i → data_o/data_val_o stable; cnt_ready_o=0; extra requests dropped; single handshake when ready rises.
- Assert arstn_i low mid-BUILD (cnt_i=8, after 3 cycles) → data_val_o=0 immediately; state IDLE and lfsr=LFSR_SEED after release; next request with cnt_i=8 reproduces the same word as a fresh-reset run.
- Loopback into the population counter for 1000 random cnt_i in 0..DATA_W+3 → counter result equals min(cnt_i, DATA_W) for every transaction.
